// File: rtl/and_seq_pkg.sv
// and_seq_pkg: shared opcodes, register codes, instruction fields and FSM states
package and_seq_pkg;
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [1:0] REG_AX = 2'b00;
  localparam logic [1:0] REG_BX = 2'b01;
  localparam logic [1:0] REG_CX = 2'b10;
  localparam logic [1:0] REG_DX = 2'b11;
  localparam int OP_LSB  = 4;
  localparam int DST_LSB = 2;
  localparam int SRC_LSB = 0;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;
  function automatic logic [3:0] op_of(input logic [7:0] w);
    return w[OP_LSB +: 4];
  endfunction
  function automatic logic [1:0] dst_of(input logic [7:0] w);
    return w[DST_LSB +: 2];
  endfunction
  function automatic logic [1:0] src_of(input logic [7:0] w);
    return w[SRC_LSB +: 2];
  endfunction
endpackage

// File: rtl/and_seq_prog_mem.sv
// and_seq_prog_mem: program store with synchronous write and registered read, not reset
module and_seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  // write port and registered read port share the clock; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/and_seq_issuer.sv
// and_seq_issuer: steps through program memory, drives the execute unit and writes back registers
module and_seq_issuer
  import and_seq_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              rf_wr_en,
  input  logic [1:0]        rf_wr_sel,
  input  logic [1:0]        rf_wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        kop,
  output logic [1:0]        sel_dst,
  output logic [1:0]        sel_src,
  output logic [1:0]        ax,
  output logic [1:0]        bx,
  output logic [1:0]        cx,
  output logic [1:0]        dx,
  input  logic [1:0]        ax_res,
  input  logic [1:0]        bx_res,
  input  logic [1:0]        cx_res,
  input  logic [1:0]        dx_res
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_DEPTH - 1);
  state_t state;
  logic [7:0] ir;
  logic [7:0] rdata;
  logic [ADDR_W-1:0] raddr;
  logic mem_we;
  logic in_exec;
  logic pre;
  assign in_exec = state == EXEC;
  // read address runs one step ahead so the word for pc is ready when FETCH samples it
  assign raddr = (state == IDLE) ? '0 : pc + {{(ADDR_W-1){1'b0}}, in_exec};
  assign mem_we = (state == IDLE) && load_en && !start;
  assign pre = (state == IDLE) && rf_wr_en && !start;
  assign kop = in_exec ? op_of(ir) : OP_NOP;
  assign sel_dst = in_exec ? dst_of(ir) : 2'b00;
  assign sel_src = in_exec ? src_of(ir) : 2'b00;
  and_seq_prog_mem #(.DEPTH(PROG_DEPTH), .AW(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (raddr),
    .rdata (rdata)
  );
  // sequencer: fetch/execute loop with registered busy/done and register writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ax <= '0;
      bx <= '0;
      cx <= '0;
      dx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            pc <= '0;
            busy <= 1'b1;
          end
          if (pre) begin
            ax <= (rf_wr_sel == REG_AX) ? rf_wr_data : ax;
            bx <= (rf_wr_sel == REG_BX) ? rf_wr_data : bx;
            cx <= (rf_wr_sel == REG_CX) ? rf_wr_data : cx;
            dx <= (rf_wr_sel == REG_DX) ? rf_wr_data : dx;
          end
        end
        FETCH: begin
          ir <= rdata;
          state <= EXEC;
        end
        EXEC: begin
          if (op_of(ir) == OP_HALT) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            ax <= ax_res;
            bx <= bx_res;
            cx <= cx_res;
            dx <= dx_res;
            if (pc == LAST) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              pc <= pc + 1'b1;
              state <= FETCH;
            end
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_and_seq_issuer.sv
// tb_and_seq_issuer: random and directed programs checked against a program-level reference model
module tb_and_seq_issuer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_en = 1'b0;
  logic [3:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic rf_wr_en = 1'b0;
  logic [1:0] rf_wr_sel = '0;
  logic [1:0] rf_wr_data = '0;
  logic start = 1'b0;
  logic busy, done;
  logic [3:0] pc, kop;
  logic [1:0] sel_dst, sel_src, ax, bx, cx, dx;
  logic [1:0] ax_res, bx_res, cx_res, dx_res;
  int checks = 0;
  int passed = 0;
  logic [7:0] prog [16];
  logic [1:0] ireg [4];
  logic [1:0] mreg [4];
  logic [3:0] kop_c2;
  logic [1:0] ax_c3;
  always #5 clk = ~clk;
  and_seq_issuer dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data), .start(start),
    .busy(busy), .done(done), .pc(pc), .kop(kop), .sel_dst(sel_dst), .sel_src(sel_src),
    .ax(ax), .bx(bx), .cx(cx), .dx(dx),
    .ax_res(ax_res), .bx_res(bx_res), .cx_res(cx_res), .dx_res(dx_res)
  );
  // external execute unit: AND modifies dst, everything else passes registers through
  always_comb begin
    logic [3:0][1:0] r;
    r = {dx, cx, bx, ax};
    if (kop == 4'b0111) r[sel_dst] = r[sel_dst] & r[sel_src];
    ax_res = r[0];
    bx_res = r[1];
    cx_res = r[2];
    dx_res = r[3];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      load_en = 1'b1;
      load_addr = 4'(i);
      load_data = prog[i];
      rf_wr_en = i < 4;
      rf_wr_sel = 2'(i);
      rf_wr_data = (i < 4) ? ireg[i] : 2'b00;
      tick();
    end
    load_en = 1'b0;
    rf_wr_en = 1'b0;
    tick();
  endtask
  task automatic model(output int cyc, output int epc);
    logic [7:0] w;
    mreg = ireg;
    cyc = 33;
    epc = 15;
    for (int i = 0; i < 16; i++) begin
      w = prog[i];
      if (w[7:4] == 4'hF) begin
        cyc = 2 * i + 3;
        epc = i;
        break;
      end
      if (w[7:4] == 4'h7) mreg[w[3:2]] = mreg[w[3:2]] & mreg[w[1:0]];
    end
  endtask
  // mode 0: plain; 1: pokes start/load/preload mid-run; 2: load+preload alongside start
  task automatic go(input int mode, output int cyc, output bit bok);
    start = 1'b1;
    if (mode == 2) begin
      rf_wr_en = 1'b1;
      rf_wr_sel = 2'b00;
      rf_wr_data = ~ireg[0];
      load_en = 1'b1;
      load_addr = 4'd1;
      load_data = 8'hF0;
    end
    tick();
    start = 1'b0;
    rf_wr_en = 1'b0;
    load_en = 1'b0;
    cyc = 1;
    bok = 1'b1;
    while (done !== 1'b1 && cyc < 100) begin
      bok &= (busy === 1'b1);
      if (cyc == 2) kop_c2 = kop;
      if (cyc == 3) ax_c3 = ax;
      start = (mode == 1) && (cyc == 4 || cyc == 5);
      load_en = start;
      load_addr = 4'd0;
      load_data = 8'hF0;
      rf_wr_en = start;
      rf_wr_sel = 2'b00;
      rf_wr_data = ~ax;
      tick();
      cyc++;
    end
    start = 1'b0;
    load_en = 1'b0;
    rf_wr_en = 1'b0;
  endtask
  task automatic run(input string tag, input bit do_load, input int mode);
    int cyc, ecyc, epc;
    bit bok;
    if (do_load) load_prog();
    model(ecyc, epc);
    go(mode, cyc, bok);
    check({tag, " done_cycle"}, cyc, ecyc);
    check({tag, " busy_during_run"}, bok, 1);
    check({tag, " busy_at_done"}, busy, 0);
    check({tag, " pc_at_done"}, pc, epc);
    check({tag, " regs"}, {ax, bx, cx, dx}, {mreg[0], mreg[1], mreg[2], mreg[3]});
    tick();
    check({tag, " done_one_cycle"}, done, 0);
  endtask
  task automatic fill_nop();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask
  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    check("reset pc", pc, 0);
    check("reset busy_done", {busy, done}, 2'b00);
    check("reset kop_sel", {kop, sel_dst, sel_src}, 8'h00);
    check("reset regs", {ax, bx, cx, dx}, 8'h00);
    fill_nop();
    prog[0] = 8'b0111_00_01;
    prog[1] = 8'hF0;
    ireg = '{2'b11, 2'b10, 2'b00, 2'b00};
    run("single_and", 1, 0);
    check("single_and kop_exec", kop_c2, 4'b0111);
    check("single_and ax_after_exec", ax_c3, 2'b10);
    fill_nop();
    prog[0] = 8'b0111_11_10;
    prog[1] = 8'b0111_10_10;
    prog[2] = 8'hF0;
    ireg = '{2'b00, 2'b00, 2'b01, 2'b11};
    run("self_and", 1, 0);
    fill_nop();
    prog[0] = 8'b0011_00_01;
    prog[1] = 8'hF0;
    ireg = '{2'b11, 2'b01, 2'b10, 2'b00};
    run("non_and", 1, 0);
    check("non_and kop_exec", kop_c2, 4'b0011);
    fill_nop();
    ireg = '{2'b01, 2'b10, 2'b11, 2'b01};
    run("full_depth", 1, 0);
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 16; i++) begin
        int c;
        c = $urandom_range(0, 11);
        prog[i][3:0] = 4'($urandom);
        prog[i][7:4] = (c < 6) ? 4'h7 : (c < 8) ? 4'h0 : (c == 8) ? 4'hF : 4'($urandom);
      end
      for (int i = 0; i < 4; i++) ireg[i] = 2'($urandom);
      run($sformatf("random%0d", n), 1, 0);
    end
    fill_nop();
    prog[0] = 8'b0111_00_01;
    prog[2] = 8'b0111_10_11;
    ireg = '{2'b11, 2'b01, 2'b11, 2'b10};
    run("ignored_busy", 1, 1);
    ireg = mreg;
    run("rerun_mem_intact", 0, 0);
    fill_nop();
    ireg = '{2'b10, 2'b01, 2'b00, 2'b11};
    load_prog();
    run("start_drops_preload", 0, 2);
    fill_nop();
    prog[0] = 8'b0111_00_01;
    ireg = '{2'b11, 2'b11, 2'b01, 2'b10};
    load_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_reset in_exec", kop, 4'b0111);
    rst_n = 1'b0;
    #1;
    check("midrun_reset pc_busy_done", {pc, busy, done}, 6'h00);
    check("midrun_reset kop_sel", {kop, sel_dst, sel_src}, 8'h00);
    check("midrun_reset regs", {ax, bx, cx, dx}, 8'h00);
    rst_n = 1'b1;
    tick();
    check("after_reset idle", {busy, done, kop}, 6'h00);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
